bram_row_writer: RTL and testbench

BRAM_ROW_WRITER -- requirements
Module: bram_row_writer

---
 rtl/bram_row_writer_if.sv | 14 +
 rtl/bram_row_writer.sv | 93 +++++++++
 tb/tb_bram_row_writer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_row_writer_if.sv
// Write-side BRAM bus driven by bram_row_writer: port enable, write enable,
// address and data.
interface bram_row_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic                     o_bram_en;
  logic                     o_bram_we;
  logic [ADDR_W-1:0]        o_bram_addr;
  logic signed [DATA_W-1:0] o_bram_din;

  modport master (output o_bram_en, output o_bram_we, output o_bram_addr, output o_bram_din);
  modport slave  (input  o_bram_en, input  o_bram_we, input  o_bram_addr, input  o_bram_din);
endinterface

// File: rtl/bram_row_writer.sv
// Captures one N-element row and writes it to consecutive BRAM addresses
// (base+k, wrapping), with back-pressure via i_hold and a one-cycle done pulse.
module bram_row_writer #(
  parameter int DATA_W = 16,
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic signed [DATA_W-1:0] i_row [N-1:0],
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic                     i_hold,
  bram_row_writer_if.master        bram,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int IDX_W = $clog2(N + 1);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]        base_q;
  logic signed [DATA_W-1:0] buf_q [N-1:0];
  logic [SEL_W-1:0]         sel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (i_start) begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD: state_d = WRITE;
      WRITE: if (!i_hold) begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Row and base are snapshotted at start so later input changes are harmless.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q  <= '0;
      base_q <= '0;
      for (int unsigned k = 0; k < N; k++) buf_q[k] <= '0;
    end else begin
      idx_q <= idx_d;
      if (state_q == IDLE && i_start) begin
        base_q <= i_base_addr;
        buf_q  <= i_row;
      end
    end
  end

  always_comb begin
    sel              = SEL_W'(idx_q);
    bram.o_bram_en   = 1'b0;
    bram.o_bram_we   = 1'b0;
    bram.o_bram_addr = '0;
    bram.o_bram_din  = '0;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD: o_busy = 1'b1;
      WRITE: begin
        o_busy           = 1'b1;
        bram.o_bram_en   = !i_hold;
        bram.o_bram_we   = !i_hold;
        bram.o_bram_addr = base_q + ADDR_W'(idx_q);
        bram.o_bram_din  = buf_q[sel];
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bram_row_writer.sv
// Scoreboard bench for bram_row_writer: stimulus queues expected writes and
// done cycles, a negedge monitor pops and compares them.
module tb_bram_row_writer;
  localparam int DW = 16;
  localparam int NN = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0]        a;
    logic signed [DW-1:0] d;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic signed [DW-1:0] row_in  [NN-1:0];
  logic signed [DW-1:0] row_exp [NN-1:0];
  logic [AW-1:0]        i_base;
  logic                 i_hold;
  logic                 o_busy;
  logic                 o_done;

  bram_row_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

  bram_row_writer #(.DATA_W(DW), .N(NN), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (i_start),
    .i_row       (row_in),
    .i_base_addr (i_base),
    .i_hold      (i_hold),
    .bram        (bif),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int wr_cnt = 0;
  int mon_cyc;
  int mon_done;
  wr_t mon_e;
  wr_t exp_q [$];
  int  done_q [$];
  logic signed [DW-1:0] mem [NN];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every negedge, compare whatever the DUT presents.
  always @(negedge clk) begin
    mon_cyc = edge_cnt - start_edge + 1;
    chk("en_eq_we", bif.o_bram_we, bif.o_bram_en);
    if (bif.o_bram_en && bif.o_bram_we) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d din %0d expected no write",
                 bif.o_bram_addr, bif.o_bram_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", bif.o_bram_addr, mon_e.a);
        chk("wr_data", bif.o_bram_din, mon_e.d);
      end
      mem[bif.o_bram_addr] = bif.o_bram_din;
      wr_cnt++;
    end else if (i_hold) begin
      chk("hold_en", bif.o_bram_en, 0);
      if (exp_q.size() > 0) begin
        chk("hold_addr", bif.o_bram_addr, exp_q[0].a);
        chk("hold_din", bif.o_bram_din, exp_q[0].d);
      end
    end else begin
      chk("idle_addr", bif.o_bram_addr, 0);
      chk("idle_din", bif.o_bram_din, 0);
    end
    if (o_done) begin
      if (done_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", mon_cyc);
      end else begin
        mon_done = done_q.pop_front();
        chk("done_cycle", mon_cyc, mon_done);
      end
    end
  end

  task automatic set_row(input int mode);
    for (int k = 0; k < NN; k++) begin
      case (mode)
        0:       row_in[k] = DW'(k - 16);
        1:       row_in[k] = DW'(100 + k);
        2:       row_in[k] = (k % 2 == 1) ? 16'sd32767 : -16'sd32768;
        default: row_in[k] = DW'(7 * k - 50);
      endcase
    end
  endtask

  task automatic start_row(input logic [AW-1:0] base, input int done_cyc);
    wr_t e;
    row_exp = row_in;
    for (int k = 0; k < NN; k++) begin
      mem[k] = 16'sh5A5A;
      e.a = base + AW'(k);
      e.d = row_in[k];
      exp_q.push_back(e);
    end
    done_q.push_back(done_cyc);
    @(negedge clk);
    i_base  = base;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    i_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 80; c++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size() + done_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
  endtask

  task automatic check_mem(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int k = 0; k < NN; k++) begin
      a = base + AW'(k);
      chk("mem_word", mem[a], row_exp[k]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_en"},   bif.o_bram_en, 0);
    chk({tag, "_we"},   bif.o_bram_we, 0);
    chk({tag, "_addr"}, bif.o_bram_addr, 0);
    chk({tag, "_din"},  bif.o_bram_din, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    rst = 1'b1; i_start = 1'b0; i_hold = 1'b0; i_base = '0;
    for (int k = 0; k < NN; k++) row_in[k] = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic row, base 0, no holds.
    set_row(0);
    w0 = wr_cnt;
    start_row(5'd0, 34);
    wait_drain();
    check_mem(5'd0);
    chk("basic_count", wr_cnt - w0, 32);

    // Address wrap from base 30.
    set_row(1);
    start_row(5'd30, 34);
    wait_drain();
    check_mem(5'd30);

    // Hold 3 cycles on element 5 (cycles 7..9), 2 cycles on element 31 (36..37).
    set_row(3);
    w0 = wr_cnt;
    start_row(5'd3, 39);
    for (int c = 1; c <= 40; c++) begin
      i_hold = ((c >= 7 && c <= 9) || (c >= 36 && c <= 37));
      @(posedge clk);
      #1;
    end
    i_hold = 1'b0;
    wait_drain();
    check_mem(5'd3);
    chk("hold_count", wr_cnt - w0, 32);

    // Inputs scrambled and start re-pulsed in cycles 1..34 (34 is DONE).
    set_row(1);
    start_row(5'd0, 34);
    for (int c = 1; c <= 34; c++) begin
      for (int k = 0; k < NN; k++) row_in[k] = DW'($urandom);
      i_base  = AW'($urandom);
      i_start = (c % 3 != 0) || (c == 34);
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    wait_drain();
    check_mem(5'd0);

    // Reset asserted while element 10 is on the bus.
    set_row(0);
    w0 = wr_cnt;
    start_row(5'd0, 34);
    for (int c = 0; c < 40; c++) begin
      if (wr_cnt - w0 == 10) break;
      @(posedge clk);
      #1;
    end
    chk("pre_reset_writes", wr_cnt - w0, 10);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_writes", wr_cnt - w0, 10);
    check_outputs_zero("post_reset");
    set_row(3);
    start_row(5'd7, 34);
    wait_drain();
    check_mem(5'd7);

    // Extreme values; busy must cover exactly cycles 1..34.
    set_row(2);
    start_row(5'd0, 34);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      chk("busy_window", o_busy, (c <= 34) ? 1 : 0);
    end
    wait_drain();
    check_mem(5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
